demux_4_stream: RTL and testbench

DEMUX_4_STREAM -- requirements
Module: demux_4_stream

---
 rtl/demux_pkg.sv | 17 +
 rtl/stream_fifo.sv | 54 +++++
 rtl/demux_4_stream.sv | 71 +++++++
 tb/tb_demux_4_stream.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the four-channel stream demultiplexer: channel count,
// channel select type and accepted-word counter width.
package demux_pkg;

  localparam int num_channels     = 4;
  localparam int word_count_width = 16;

  typedef logic [1:0]                  chan_sel_t;
  typedef logic [word_count_width-1:0] word_count_t;

  // One-hot decode of a channel select, used to steer the push strobe.
  function automatic logic [num_channels-1:0] chan_onehot(input chan_sel_t sel);
    chan_onehot      = '0;
    chan_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Per-channel FIFO with registered storage; the head word is presented
// directly from the storage array so a push is visible one edge later.
module stream_fifo #(
  parameter int data_width = 16,
  parameter int depth      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [data_width-1:0] din,
  output logic [data_width-1:0] dout,
  output logic                  empty,
  output logic                  full
);

  localparam int aw = (depth > 1) ? $clog2(depth) : 1;
  localparam int cw = $clog2(depth + 1);

  logic [data_width-1:0] mem_reg [depth];
  logic [aw-1:0]         wr_ptr_reg;
  logic [aw-1:0]         rd_ptr_reg;
  logic [cw-1:0]         count_reg;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == cw'(depth));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_reg[rd_ptr_reg];

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_reg[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/demux_4_stream.sv
// Routes one ready/valid input stream to one of four buffered output streams
// selected per word, and counts accepted words.
module demux_4_stream
  import demux_pkg::*;
#(
  parameter int data_width = 16,
  parameter int depth      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [data_width-1:0]   in_data,
  input  chan_sel_t               in_sel,
  output logic [data_width-1:0]   out_data_0,
  output logic [data_width-1:0]   out_data_1,
  output logic [data_width-1:0]   out_data_2,
  output logic [data_width-1:0]   out_data_3,
  output logic [num_channels-1:0] out_valid,
  input  logic [num_channels-1:0] out_ready,
  output word_count_t             word_count
);

  logic [num_channels-1:0] full_w;
  logic [num_channels-1:0] empty_w;
  logic [num_channels-1:0] push_w;
  logic [num_channels-1:0] pop_w;
  logic [data_width-1:0]   dout_w [num_channels];
  logic                    accept_w;
  word_count_t             word_count_reg;

  // Readiness looks only at the pre-edge fill level, so a full channel
  // refuses input even while it is being drained.
  assign in_ready = !full_w[in_sel];
  assign accept_w = in_valid && in_ready;
  assign push_w   = chan_onehot(in_sel) & {num_channels{accept_w}};

  generate
    for (genvar gi = 0; gi < num_channels; gi++) begin : g_chan
      assign out_valid[gi] = !empty_w[gi];
      assign pop_w[gi]     = !empty_w[gi] && out_ready[gi];

      stream_fifo #(
        .data_width (data_width),
        .depth      (depth)
      ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_w[gi]),
        .pop   (pop_w[gi]),
        .din   (in_data),
        .dout  (dout_w[gi]),
        .empty (empty_w[gi]),
        .full  (full_w[gi])
      );
    end
  endgenerate

  assign out_data_0 = dout_w[0];
  assign out_data_1 = dout_w[1];
  assign out_data_2 = dout_w[2];
  assign out_data_3 = dout_w[3];

  always_ff @(posedge clk) begin
    if (reset)         word_count_reg <= '0;
    else if (accept_w) word_count_reg <= word_count_reg + 1'b1;
  end

  assign word_count = word_count_reg;

endmodule

// File: tb/tb_demux_4_stream.sv
// Self-checking bench for demux_4_stream: per-channel queue model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_demux_4_stream;

  localparam int DW    = 16;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_sel;
  logic [DW-1:0] out_data_0, out_data_1, out_data_2, out_data_3;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [15:0]   word_count;

  logic [DW-1:0] od [4];
  assign od[0] = out_data_0;
  assign od[1] = out_data_1;
  assign od[2] = out_data_2;
  assign od[3] = out_data_3;

  demux_4_stream #(.data_width(DW), .depth(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out_data_0 (out_data_0),
    .out_data_1 (out_data_1),
    .out_data_2 (out_data_2),
    .out_data_3 (out_data_3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  bit          chk_en   = 1'b0;
  logic [DW-1:0] q [4][$];
  logic [15:0] m_wc = '0;
  int          dut_accepts = 0;
  int          pops_total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Reference model: each channel is a bounded queue of depth entries.
  always @(posedge clk) begin : model
    bit       do_push;
    bit [3:0] do_pop;
    if (reset) begin
      for (int n = 0; n < 4; n++) q[n].delete();
      m_wc = '0;
    end else begin
      do_push = in_valid && (q[in_sel].size() < DEPTH);
      for (int n = 0; n < 4; n++) do_pop[n] = (q[n].size() > 0) && out_ready[n];
      if (in_valid && in_ready) dut_accepts++;
      for (int n = 0; n < 4; n++)
        if (do_pop[n]) begin
          void'(q[n].pop_front());
          pops_total++;
        end
      if (do_push) begin
        q[in_sel].push_back(in_data);
        m_wc = m_wc + 16'd1;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [3:0] exp_v;
    if (chk_en) begin
      for (int n = 0; n < 4; n++) exp_v[n] = (q[n].size() > 0);
      chk("model_out_valid", out_valid, exp_v);
      chk("model_in_ready", in_ready, (q[in_sel].size() < DEPTH) ? 1 : 0);
      chk("model_word_count", word_count, m_wc);
      for (int n = 0; n < 4; n++)
        if (q[n].size() > 0) chk("model_out_data", od[n], q[n][0]);
    end
  end

  task automatic drive(input bit v, input logic [1:0] s, input logic [DW-1:0] d,
                       input logic [3:0] r, input bit rst);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    reset     = rst;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 4'b0000, 1);
    step();
    drive(0, 0, 0, 4'b0000, 0);
  endtask

  initial begin
    drive(0, 0, 0, 4'b0000, 1);
    step();
    step();
    chk_en = 1'b1;
    $display("txn reset");
    chk("reset_out_valid", out_valid, 4'b0000);
    chk("reset_word_count", word_count, 16'd0);
    chk("reset_in_ready", in_ready, 1'b1);
    drive(0, 0, 0, 4'b0000, 0);

    // Single push to channel 2
    drive(1, 2, 16'hA5A5, 4'b0000, 0);
    step();
    drive(0, 0, 0, 4'b0000, 0);
    $display("txn push A5A5 sel=2");
    chk("push_out_valid", out_valid, 4'b0100);
    chk("push_out_data_2", out_data_2, 16'hA5A5);
    chk("push_word_count", word_count, 16'd1);

    // Fill channel 1 and probe readiness
    do_reset();
    drive(1, 1, 16'h0001, 4'b0000, 0);
    step();
    drive(1, 1, 16'h0002, 4'b0000, 0);
    step();
    drive(1, 1, 16'h0003, 4'b0000, 0);
    #1;
    $display("txn fill ch1");
    chk("full_in_ready_sel1", in_ready, 1'b0);
    in_sel = 2'd0;
    #1;
    chk("full_in_ready_sel0", in_ready, 1'b1);

    // Full channel with a simultaneous pop still refuses the push
    drive(1, 1, 16'h0003, 4'b0010, 0);
    #1;
    chk("fullpop_in_ready", in_ready, 1'b0);
    chk("fullpop_head", out_data_1, 16'h0001);
    step();
    drive(0, 1, 0, 4'b0000, 0);
    #1;
    $display("txn full push+pop ch1");
    chk("fullpop_next_head", out_data_1, 16'h0002);
    chk("fullpop_out_valid", out_valid, 4'b0010);
    chk("fullpop_word_count", word_count, 16'd2);
    chk("fullpop_in_ready_after", in_ready, 1'b1);

    // Streaming through a one-entry channel 3
    do_reset();
    drive(1, 3, 16'd100, 4'b0000, 0);
    step();
    chk("ch3_one_entry", out_valid, 4'b1000);
    for (int i = 1; i <= 8; i++) begin
      drive(1, 3, 16'(100 + i), 4'b1000, 0);
      step();
      $display("txn ch3 push+pop word=%0d", 100 + i);
      chk("ch3_stream_data", out_data_3, 16'(100 + i));
      chk("ch3_stream_valid", out_valid, 4'b1000);
    end
    drive(0, 0, 0, 4'b1000, 0);
    step();
    chk("ch3_drained", out_valid, 4'b0000);

    // Reset with every channel loaded and a push pending
    do_reset();
    for (int n = 0; n < 4; n++) begin
      drive(1, 2'(n), 16'(16'h1000 + n), 4'b0000, 0);
      step();
    end
    chk("loaded_out_valid", out_valid, 4'b1111);
    drive(1, 0, 16'hBEEF, 4'b0000, 1);
    step();
    $display("txn reset with in_valid=1");
    chk("rst_push_out_valid", out_valid, 4'b0000);
    chk("rst_push_word_count", word_count, 16'd0);
    drive(0, 0, 0, 4'b0000, 0);
    step();
    chk("rst_push_no_push", out_valid, 4'b0000);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 16'($urandom),
            4'($urandom), $urandom_range(0, 63) == 0);
      step();
    end
    $display("txn random phase done");

    // Counter wrap with all consumers always ready
    do_reset();
    dut_accepts = 0;
    pops_total  = 0;
    for (int i = 0; i < 65536; i++) begin
      drive(1, 2'($urandom_range(0, 3)), 16'($urandom), 4'b1111, 0);
      step();
    end
    drive(0, 0, 0, 4'b1111, 0);
    step();
    $display("txn 65536 pushes");
    chk("wrap_word_count", word_count, 16'h0000);
    chk("wrap_accepts", dut_accepts, 65536);
    chk("wrap_all_drained", pops_total, 65536);
    chk("wrap_out_valid", out_valid, 4'b0000);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
